// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR CV-X-IF extension unit: pipeline payloads, EX state
// encoding and small helpers used across stages.
package fir_xifu_pkg;

  typedef enum logic [1:0] {
    INSTR_LDTAP = 2'd0,
    INSTR_LDSAM = 2'd1,
    INSTR_STSAM = 2'd2
  } fir_xifu_instr_t;

  typedef struct packed {
    fir_xifu_instr_t instr;
    logic [31:0]     base;
    logic [11:0]     offset;
    logic            store;
    logic [4:0]      register;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    logic [31:0] sample;
  } fir_xifu_ctrl2ex_t;

  typedef struct packed {
    fir_xifu_instr_t instr;
    logic [31:0]     next_addr;
    logic [4:0]      register;
  } fir_xifu_ex2wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } fir_xifu_ex_state_t;

  localparam logic [3:0] MEM_BE_WORD = 4'hF;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR X-IF unit: holds one instruction, issues its single
// memory request, then presents the post-incremented address to WB.
module fir_xifu_ex
  import fir_xifu_pkg::*;
#(
  parameter int IdWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  fir_xifu_id2ex_t     id2ex_i,
  input  logic [IdWidth-1:0]  id2ex_id_i,
  input  logic                id2ex_valid_i,
  output logic                id2ex_ready_o,
  input  fir_xifu_ctrl2ex_t   ctrl2ex_i,
  input  logic                kill_i,
  input  logic [IdWidth-1:0]  kill_id_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_wdata_o,
  output logic [IdWidth-1:0]  mem_id_o,
  output fir_xifu_ex2wb_t     ex2wb_o,
  output logic [IdWidth-1:0]  ex2wb_id_o,
  output logic                ex2wb_valid_o,
  input  logic                ex2wb_ready_i,
  output logic                err_o
);

  fir_xifu_ex_state_t state_q, state_d;
  logic [31:0]        addr_q, wdata_q;
  logic               we_q, err_q;
  logic [IdWidth-1:0] id_q;
  fir_xifu_ex2wb_t    ex2wb_q;

  logic accept, misaligned, load, kill_hit;

  assign id2ex_ready_o = (state_q == IDLE) | ((state_q == OUT) & ex2wb_ready_i);
  assign accept        = id2ex_valid_i & id2ex_ready_o;
  assign misaligned    = id2ex_i.base[1:0] != 2'b00;
  assign load          = accept & ~misaligned;
  // A kill only withdraws a request the memory has not yet taken.
  assign kill_hit      = kill_i & (kill_id_i == id_q) & ~mem_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      REQ:     if (mem_ready_i) state_d = OUT;
               else if (kill_hit) state_d = IDLE;
      OUT:     if (ex2wb_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) state_d = REQ;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      ex2wb_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & misaligned;
      if (load) begin
        addr_q            <= id2ex_i.base;
        we_q              <= id2ex_i.store;
        wdata_q           <= (id2ex_i.instr == INSTR_STSAM) ? ctrl2ex_i.sample : 32'h0;
        id_q              <= id2ex_id_i;
        ex2wb_q.instr     <= id2ex_i.instr;
        ex2wb_q.register  <= id2ex_i.register;
        ex2wb_q.next_addr <= id2ex_i.base + sext12(id2ex_i.offset);
      end
    end
  end

  assign mem_valid_o   = state_q == REQ;
  assign mem_addr_o    = addr_q;
  assign mem_we_o      = we_q;
  assign mem_be_o      = MEM_BE_WORD;
  assign mem_wdata_o   = wdata_q;
  assign mem_id_o      = id_q;
  assign ex2wb_valid_o = state_q == OUT;
  assign ex2wb_o       = ex2wb_q;
  assign ex2wb_id_o    = id_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Bench for fir_xifu_ex: vector table, directed corner sequences, then random
// traffic against a queue-based transaction model.
module tb_fir_xifu_ex;
  import fir_xifu_pkg::*;

  localparam int IdWidth = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_xifu_id2ex_t   id2ex;
  fir_xifu_ctrl2ex_t ctrl2ex;
  fir_xifu_ex2wb_t   ex2wb;
  logic [IdWidth-1:0] id2ex_id, kill_id, mem_id, ex2wb_id;
  logic id2ex_valid, id2ex_ready, kill, mem_valid, mem_ready, mem_we;
  logic ex2wb_valid, ex2wb_ready, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  fir_xifu_ex #(.IdWidth(IdWidth)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id2ex_i(id2ex), .id2ex_id_i(id2ex_id), .id2ex_valid_i(id2ex_valid), .id2ex_ready_o(id2ex_ready),
    .ctrl2ex_i(ctrl2ex), .kill_i(kill), .kill_id_i(kill_id),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_id_o(mem_id),
    .ex2wb_o(ex2wb), .ex2wb_id_o(ex2wb_id), .ex2wb_valid_o(ex2wb_valid), .ex2wb_ready_i(ex2wb_ready),
    .err_o(err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input fir_xifu_instr_t ins, input logic [31:0] base, input logic [11:0] off,
                       input logic [3:0] id, input logic [4:0] rg);
    id2ex.instr    = ins;
    id2ex.base     = base;
    id2ex.offset   = off;
    id2ex.store    = (ins == INSTR_STSAM);
    id2ex.register = rg;
    id2ex_id       = id;
    id2ex_valid    = 1'b1;
  endtask

  typedef struct {
    string           name;
    fir_xifu_instr_t instr;
    logic [31:0]     base;
    logic [11:0]     off;
    logic [3:0]      id;
    logic [31:0]     sample;
    logic            exp_we;
    logic [31:0]     exp_wdata;
    logic [31:0]     exp_next;
    logic            exp_err;
  } vec_t;

  typedef struct {
    fir_xifu_instr_t instr;
    logic [31:0]     addr, next, wdata;
    logic            we;
    logic [4:0]      rg;
    logic [3:0]      id;
  } ent_t;

  vec_t tbl[6];
  ent_t reqq[$], wbq[$];

  initial begin
    tbl[0] = '{"ldsam",  INSTR_LDSAM, 32'h0000_1000, 12'h004, 4'd3, 32'h1111_1111, 1'b0, 32'h0,          32'h0000_1004, 1'b0};
    tbl[1] = '{"ldtap",  INSTR_LDTAP, 32'h0000_0000, 12'h004, 4'd1, 32'h2222_2222, 1'b0, 32'h0,          32'h0000_0004, 1'b0};
    tbl[2] = '{"stsam",  INSTR_STSAM, 32'h0000_3000, 12'h010, 4'd7, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 32'h0000_3010, 1'b0};
    tbl[3] = '{"wrap",   INSTR_LDSAM, 32'hFFFF_FFFC, 12'h008, 4'd2, 32'h0,         1'b0, 32'h0,          32'h0000_0004, 1'b0};
    tbl[4] = '{"misal",  INSTR_LDSAM, 32'h0000_1002, 12'h004, 4'd4, 32'h0,         1'b0, 32'h0,          32'h0,         1'b1};
    tbl[5] = '{"negoff", INSTR_STSAM, 32'h8000_0000, 12'h800, 4'd9, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h7FFF_F800, 1'b0};

    id2ex = '0; id2ex_id = '0; id2ex_valid = 1'b0; ctrl2ex = '0;
    kill = 1'b0; kill_id = '0; mem_ready = 1'b0; ex2wb_ready = 1'b0;

    // reset state
    cyc(); cyc(); #1;
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst ex2wb_valid", 32'(ex2wb_valid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst ready", 32'(id2ex_ready), 32'd1);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst next_addr", ex2wb.next_addr, 32'h0);
    chk("rst be", 32'(mem_be), 32'hF);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc();
      offer(tbl[i].instr, tbl[i].base, tbl[i].off, tbl[i].id, 5'(i));
      ctrl2ex.sample = tbl[i].sample; mem_ready = 1'b1; ex2wb_ready = 1'b1;
      #1 chk({tbl[i].name, " ready"}, 32'(id2ex_ready), 32'd1);
      cyc(); id2ex_valid = 1'b0; ctrl2ex.sample = 32'h0; #1;
      chk({tbl[i].name, " mem_valid"}, 32'(mem_valid), 32'(!tbl[i].exp_err));
      chk({tbl[i].name, " err"}, 32'(err), 32'(tbl[i].exp_err));
      if (!tbl[i].exp_err) begin
        chk({tbl[i].name, " addr"}, mem_addr, tbl[i].base);
        chk({tbl[i].name, " we"}, 32'(mem_we), 32'(tbl[i].exp_we));
        chk({tbl[i].name, " wdata"}, mem_wdata, tbl[i].exp_wdata);
        chk({tbl[i].name, " mem_id"}, 32'(mem_id), 32'(tbl[i].id));
      end
      cyc(); #1;
      chk({tbl[i].name, " wb_valid"}, 32'(ex2wb_valid), 32'(!tbl[i].exp_err));
      chk({tbl[i].name, " err clr"}, 32'(err), 32'd0);
      chk({tbl[i].name, " mem_valid clr"}, 32'(mem_valid), 32'd0);
      if (!tbl[i].exp_err) begin
        chk({tbl[i].name, " next_addr"}, ex2wb.next_addr, tbl[i].exp_next);
        chk({tbl[i].name, " wb_id"}, 32'(ex2wb_id), 32'(tbl[i].id));
        chk({tbl[i].name, " wb_reg"}, 32'(ex2wb.register), i);
      end
      cyc(); #1 chk({tbl[i].name, " wb drop"}, 32'(ex2wb_valid), 32'd0);
    end

    // STSAM with memory held off for three cycles
    cyc();
    offer(INSTR_STSAM, 32'h2000, 12'hFFC, 4'd8, 5'd2);
    ctrl2ex.sample = 32'hDEAD_BEEF; mem_ready = 1'b0; ex2wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); id2ex_valid = 1'b0; ctrl2ex.sample = $urandom();
      if (k == 2) mem_ready = 1'b1;
      #1;
      chk("st hold valid", 32'(mem_valid), 32'd1);
      chk("st hold we", 32'(mem_we), 32'd1);
      chk("st hold wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st hold addr", mem_addr, 32'h2000);
      chk("st stall ready", 32'(id2ex_ready), 32'd0);
    end
    cyc(); mem_ready = 1'b0; #1;
    chk("st wb_valid", 32'(ex2wb_valid), 32'd1);
    chk("st next_addr", ex2wb.next_addr, 32'h1FFC);
    chk("st mem released", 32'(mem_valid), 32'd0);
    cyc(); #1 chk("st idle", 32'(ex2wb_valid), 32'd0);

    // back-to-back LDTAP
    cyc(); offer(INSTR_LDTAP, 32'h0, 12'h004, 4'd1, 5'd3); mem_ready = 1'b1;
    cyc(); offer(INSTR_LDTAP, 32'h4, 12'h004, 4'd2, 5'd4); #1;
    chk("b2b req0 addr", mem_addr, 32'h0);
    chk("b2b req0 valid", 32'(mem_valid), 32'd1);
    chk("b2b stall in req", 32'(id2ex_ready), 32'd0);
    cyc(); #1;
    chk("b2b out0 valid", 32'(ex2wb_valid), 32'd1);
    chk("b2b out0 next", ex2wb.next_addr, 32'h4);
    chk("b2b accept in out", 32'(id2ex_ready), 32'd1);
    cyc(); id2ex_valid = 1'b0; #1;
    chk("b2b req1 valid", 32'(mem_valid), 32'd1);
    chk("b2b req1 addr", mem_addr, 32'h4);
    chk("b2b req1 id", 32'(mem_id), 32'd2);
    chk("b2b out0 gone", 32'(ex2wb_valid), 32'd0);
    cyc(); #1 chk("b2b out1 next", ex2wb.next_addr, 32'h8);
    cyc(); #1 chk("b2b idle", 32'(ex2wb_valid), 32'd0);

    // kill with matching id
    cyc(); offer(INSTR_LDSAM, 32'h500, 12'h004, 4'd5, 5'd1); mem_ready = 1'b0;
    cyc(); id2ex_valid = 1'b0; kill = 1'b1; kill_id = 4'd5; #1;
    chk("kill req valid", 32'(mem_valid), 32'd1);
    cyc(); kill = 1'b0; #1;
    chk("kill dropped", 32'(mem_valid), 32'd0);
    chk("kill no wb", 32'(ex2wb_valid), 32'd0);
    chk("kill ready", 32'(id2ex_ready), 32'd1);
    cyc(); #1 chk("kill no wb later", 32'(ex2wb_valid), 32'd0);

    // kill with non-matching id
    cyc(); offer(INSTR_LDSAM, 32'h600, 12'h004, 4'd6, 5'd1);
    cyc(); id2ex_valid = 1'b0; kill = 1'b1; kill_id = 4'd7; #1;
    chk("nokill valid", 32'(mem_valid), 32'd1);
    cyc(); kill = 1'b0; mem_ready = 1'b1; #1;
    chk("nokill held", 32'(mem_valid), 32'd1);
    chk("nokill addr", mem_addr, 32'h600);
    cyc(); mem_ready = 1'b0; #1;
    chk("nokill wb", 32'(ex2wb_valid), 32'd1);
    chk("nokill next", ex2wb.next_addr, 32'h604);
    cyc(); #1 chk("nokill idle", 32'(ex2wb_valid), 32'd0);

    // async reset while in OUT
    cyc(); offer(INSTR_LDSAM, 32'h700, 12'h000, 4'd3, 5'd1); mem_ready = 1'b1; ex2wb_ready = 1'b0;
    cyc(); id2ex_valid = 1'b0;
    cyc(); #1;
    chk("rstout wb before", 32'(ex2wb_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("rstout wb drop", 32'(ex2wb_valid), 32'd0);
    chk("rstout mem drop", 32'(mem_valid), 32'd0);
    cyc(); rst_n = 1'b1; mem_ready = 1'b0; ex2wb_ready = 1'b1; #1;
    chk("rstout ready", 32'(id2ex_ready), 32'd1);
    chk("rstout mem idle", 32'(mem_valid), 32'd0);
    cyc(); #1 chk("rstout wb idle", 32'(ex2wb_valid), 32'd0);

    // random traffic against the transaction model
    begin
      logic err_exp = 1'b0;
      logic exp_ready;
      logic [31:0] r;
      for (int c = 0; c < 3000; c++) begin
        cyc();
        r = $urandom();
        id2ex_valid    = $urandom_range(0, 2) != 0;
        id2ex.instr    = fir_xifu_instr_t'($urandom_range(0, 2));
        id2ex.store    = (id2ex.instr == INSTR_STSAM);
        id2ex.base     = ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00};
        id2ex.offset   = 12'($urandom_range(0, 4095));
        id2ex.register = 5'($urandom_range(0, 31));
        id2ex_id       = 4'($urandom_range(0, 15));
        ctrl2ex.sample = $urandom();
        mem_ready      = $urandom_range(0, 1) != 0;
        ex2wb_ready    = $urandom_range(0, 4) > 1;
        kill           = $urandom_range(0, 3) == 0;
        kill_id        = (reqq.size() != 0 && $urandom_range(0, 1) != 0) ? reqq[0].id : 4'($urandom_range(0, 15));
        #1;
        exp_ready = (reqq.size() == 0 && wbq.size() == 0) || (wbq.size() != 0 && ex2wb_ready);
        chk("rnd ready", 32'(id2ex_ready), 32'(exp_ready));
        chk("rnd mem_valid", 32'(mem_valid), 32'(reqq.size() != 0));
        chk("rnd wb_valid", 32'(ex2wb_valid), 32'(wbq.size() != 0));
        chk("rnd err", 32'(err), 32'(err_exp));
        if (reqq.size() != 0) begin
          chk("rnd addr", mem_addr, reqq[0].addr);
          chk("rnd we", 32'(mem_we), 32'(reqq[0].we));
          chk("rnd wdata", mem_wdata, reqq[0].wdata);
          chk("rnd mem_id", 32'(mem_id), 32'(reqq[0].id));
          chk("rnd be", 32'(mem_be), 32'hF);
        end
        if (wbq.size() != 0) begin
          chk("rnd next", ex2wb.next_addr, wbq[0].next);
          chk("rnd instr", 32'(ex2wb.instr), 32'(wbq[0].instr));
          chk("rnd reg", 32'(ex2wb.register), 32'(wbq[0].rg));
          chk("rnd wb_id", 32'(ex2wb_id), 32'(wbq[0].id));
        end
        err_exp = 1'b0;
        if (wbq.size() != 0 && ex2wb_ready) void'(wbq.pop_front());
        if (reqq.size() != 0) begin
          if (mem_ready) wbq.push_back(reqq.pop_front());
          else if (kill && kill_id == reqq[0].id) void'(reqq.pop_front());
        end
        if (id2ex_valid && exp_ready) begin
          if (id2ex.base[1:0] != 2'b00) err_exp = 1'b1;
          else begin
            ent_t e;
            e.instr = id2ex.instr;
            e.addr  = id2ex.base;
            e.next  = id2ex.base + 32'(int'($signed(id2ex.offset)));
            e.we    = id2ex.instr == INSTR_STSAM;
            e.wdata = (id2ex.instr == INSTR_STSAM) ? ctrl2ex.sample : 32'h0;
            e.rg    = id2ex.register;
            e.id    = id2ex_id;
            reqq.push_back(e);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
